// File: rtl/mac_prom_loader_pkg.sv
// Shared MAC definitions: register-block word addresses, loader FSM states,
// and helpers that build the register-bus writes the PROM loader issues.
package mac_prom_loader_pkg;

    localparam logic [6:0] TX_DATA   = 7'd8;
    localparam logic [6:0] TX_ADD    = 7'd9;
    localparam logic [6:0] TX_WR     = 7'd10;
    localparam logic [6:0] RX_DATA   = 7'd15;
    localparam logic [6:0] RX_ADD    = 7'd16;
    localparam logic [6:0] RX_WR     = 7'd17;
    localparam logic [2:0] LAST_BYTE = 3'd5;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PENDING = 3'd1,
        DATA    = 3'd2,
        ADDR    = 3'd3,
        WR_HI   = 3'd4,
        WR_LO   = 3'd5,
        DONE    = 3'd6
    } state_e;

    typedef struct packed {
        logic        csb;
        logic        wrb;
        logic [7:0]  ca;
        logic [15:0] cd;
    } bus_t;

    localparam bus_t BUS_QUIET = '{csb: 1'b1, wrb: 1'b1, ca: 8'h00, cd: 16'h0000};

    function automatic logic [7:0] word_to_ca(input logic [6:0] word);
        return {word, 1'b0};
    endfunction

    function automatic logic is_load_state(input state_e st);
        logic r;
        r = 1'b0;
        case (st)
            DATA, ADDR, WR_HI, WR_LO: r = 1'b1;
            default:                  r = 1'b0;
        endcase
        return r;
    endfunction

    // Byte 0 is the most significant octet of the address.
    function automatic logic [7:0] mac_byte(input logic [47:0] addr, input logic [2:0] idx);
        logic [7:0] b;
        b = 8'h00;
        case (idx)
            3'd0:    b = addr[47:40];
            3'd1:    b = addr[39:32];
            3'd2:    b = addr[31:24];
            3'd3:    b = addr[23:16];
            3'd4:    b = addr[15:8];
            3'd5:    b = addr[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    function automatic bus_t loader_write(input state_e st, input logic rx,
                                          input logic [2:0] idx, input logic [7:0] byte_v);
        bus_t w;
        w     = BUS_QUIET;
        w.csb = 1'b0;
        w.wrb = 1'b0;
        case (st)
            DATA: begin
                w.ca = word_to_ca(rx ? RX_DATA : TX_DATA);
                w.cd = {8'h00, byte_v};
            end
            ADDR: begin
                w.ca = word_to_ca(rx ? RX_ADD : TX_ADD);
                w.cd = {13'd0, idx};
            end
            WR_HI: begin
                w.ca = word_to_ca(rx ? RX_WR : TX_WR);
                w.cd = 16'h0001;
            end
            WR_LO: begin
                w.ca = word_to_ca(rx ? RX_WR : TX_WR);
                w.cd = 16'h0000;
            end
            default: w = BUS_QUIET;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/mac_prom_loader.sv
// Loads a 48-bit MAC address into the TX or RX address PROM through the
// register bus, sharing that bus with host accesses (host has priority at launch).
module mac_prom_loader
    import mac_prom_loader_pkg::*;
(
    input  logic        Clk_reg,
    input  logic        Reset,
    input  logic        start,
    input  logic        sel_rx,
    input  logic [47:0] mac_addr,
    output logic        busy,
    output logic        done,
    input  logic        CSB_in,
    input  logic        WRB_in,
    input  logic [7:0]  CA_in,
    input  logic [15:0] CD_in_host,
    output logic        host_wait,
    output logic        CSB,
    output logic        WRB,
    output logic [7:0]  CA,
    output logic [15:0] CD_bus
);

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [47:0] addr_q, addr_d;
    logic        sel_q, sel_d;
    bus_t        bus_q, bus_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    // Next-state, byte counter and start capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        sel_d   = sel_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d  = mac_addr;
                    sel_d   = sel_rx;
                    cnt_d   = 3'd0;
                    state_d = CSB_in ? DATA : PENDING;
                end else begin
                    state_d = IDLE;
                end
            end
            PENDING: begin
                if (CSB_in) begin
                    state_d = DATA;
                end else begin
                    state_d = PENDING;
                end
            end
            DATA:  state_d = ADDR;
            ADDR:  state_d = WR_HI;
            WR_HI: state_d = WR_LO;
            WR_LO: begin
                if (cnt_q == LAST_BYTE) begin
                    cnt_d   = 3'd0;
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + 3'd1;
                    state_d = DATA;
                end
            end
            DONE: state_d = IDLE;
            default: begin
                cnt_d   = 3'd0;
                state_d = IDLE;
            end
        endcase
    end

    // Bus mux computed from the next state so a write is registered in the cycle it belongs to.
    always_comb begin
        bus_d.csb = CSB_in;
        bus_d.wrb = WRB_in | CSB_in;
        bus_d.ca  = CA_in;
        bus_d.cd  = CD_in_host;
        if (is_load_state(state_d)) begin
            bus_d = loader_write(state_d, sel_d, cnt_d, mac_byte(addr_d, cnt_d));
        end else if (state_d == DONE) begin
            bus_d.csb = 1'b1;
            bus_d.wrb = 1'b1;
        end else begin
            bus_d.csb = CSB_in;
            bus_d.wrb = WRB_in | CSB_in;
        end
    end

    // Status flags track the state the FSM enters next.
    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_d)
            IDLE:    busy_d = 1'b0;
            DONE:    done_d = 1'b1;
            default: busy_d = 1'b1;
        endcase
    end

    // State and output registers.
    always_ff @(posedge Clk_reg or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            addr_q  <= 48'd0;
            sel_q   <= 1'b0;
            bus_q   <= BUS_QUIET;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            bus_q   <= bus_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign host_wait = ~CSB_in & is_load_state(state_q);
    assign busy      = busy_q;
    assign done      = done_q;
    assign CSB       = bus_q.csb;
    assign WRB       = bus_q.wrb;
    assign CA        = bus_q.ca;
    assign CD_bus    = bus_q.cd;

endmodule
